// File: rtl/bitmask_prev_constant_popcount_enumerator_if.sv
// Handshake bundle for the descending constant-popcount bitmask enumerator.
// The master side offers start words and consumes output beats.
// The slave side is the enumerator itself.
interface bitmask_prev_constant_popcount_enumerator_if #(
   parameter int WORD_WIDTH  = 8,
   parameter int INDEX_WIDTH = 16
);
   logic                   start_valid;
   logic                   start_ready;
   logic [WORD_WIDTH-1:0]  start_word;
   logic                   out_valid;
   logic                   out_ready;
   logic [WORD_WIDTH-1:0]  out_word;
   logic                   out_last;
   logic [INDEX_WIDTH-1:0] out_index;
   logic                   busy;

   modport master (
      output start_valid, start_word, out_ready,
      input  start_ready, out_valid, out_word, out_last, out_index, busy
   );

   modport slave (
      input  start_valid, start_word, out_ready,
      output start_ready, out_valid, out_word, out_last, out_index, busy
   );
endinterface

// File: rtl/bitmask_prev_constant_popcount_enumerator.sv
// Descending constant-popcount bitmask enumerator.
// A start word is accepted in IDLE. That word and every smaller word with the
// same popcount are then streamed, one per accepted beat. The run ends on the
// word whose set bits are packed at the LSB end.
module bitmask_prev_constant_popcount_enumerator #(
   parameter int WORD_WIDTH  = 8,
   parameter int INDEX_WIDTH = 16
) (
   input logic clock,
   input logic clear,
   bitmask_prev_constant_popcount_enumerator_if.slave bus
);

   localparam int TZ_WIDTH = $clog2(WORD_WIDTH) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [WORD_WIDTH-1:0]  word_q;
   logic [INDEX_WIDTH-1:0] index_q;

   logic [WORD_WIDTH-1:0]  comp_word;
   logic [WORD_WIDTH-1:0]  lowest_one;
   logic [WORD_WIDTH-1:0]  ripple;
   logic [WORD_WIDTH-1:0]  ones;
   logic [WORD_WIDTH-1:0]  prev_word;
   logic [TZ_WIDTH-1:0]    trailing;
   logic                   word_minimal;
   logic                   beat_taken;

   // A word is the smallest of its popcount class when its ones are contiguous from bit 0.
   assign word_minimal = ((word_q & (word_q + WORD_WIDTH'(1))) == '0);
   assign beat_taken   = (state == RUN) && bus.out_ready;

   // Step one word down: complement, apply the Gosper next-mask step, complement back.
   always_comb begin
      comp_word  = ~word_q;
      trailing   = '0;
      for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
         if (comp_word[i]) trailing = TZ_WIDTH'(i);
      end
      lowest_one = comp_word & (~comp_word + WORD_WIDTH'(1));
      ripple     = comp_word + lowest_one;
      ones       = ((ripple ^ comp_word) >> 2) >> trailing;
      prev_word  = ~(ripple | ones);
   end

   // State register; clear has priority over everything else.
   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= state_next;
   end

   // Next state: a start is taken only in IDLE, and the run ends on the last accepted beat.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start_valid) state_next = RUN;
         RUN:  if (bus.out_ready && word_minimal) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Word and index registers: load on start, step down on each non-final accepted beat.
   always_ff @(posedge clock) begin
      if (clear) begin
         word_q  <= '0;
         index_q <= '0;
      end else if (state == IDLE) begin
         if (bus.start_valid) begin
            word_q  <= bus.start_word;
            index_q <= '0;
         end
      end else if (beat_taken && !word_minimal) begin
         word_q  <= prev_word;
         index_q <= index_q + INDEX_WIDTH'(1);
      end
   end

   // Outputs follow the state; out_last is only asserted while a beat is being offered.
   always_comb begin
      bus.start_ready = (state == IDLE);
      bus.out_valid   = (state == RUN);
      bus.busy        = (state == RUN);
      bus.out_last    = (state == RUN) && word_minimal;
      bus.out_word    = word_q;
      bus.out_index   = index_q;
   end

endmodule

// File: tb/tb_bitmask_prev_constant_popcount_enumerator.sv
// Bench for the descending constant-popcount enumerator.
// A 4-bit and an 8-bit instance share one clock and clear. Expected beats come
// from a brute-force downward search and are queued when a start is driven.
module tb_bitmask_prev_constant_popcount_enumerator;

   logic clock;
   logic clear;

   int vectors;
   int miscompares;

   typedef struct {
      logic [7:0] word;
      int         index;
      logic       last;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];

   bitmask_prev_constant_popcount_enumerator_if #(.WORD_WIDTH(4), .INDEX_WIDTH(16)) if4 ();
   bitmask_prev_constant_popcount_enumerator_if #(.WORD_WIDTH(8), .INDEX_WIDTH(16)) if8 ();

   bitmask_prev_constant_popcount_enumerator #(.WORD_WIDTH(4), .INDEX_WIDTH(16)) dut4 (
      .clock (clock),
      .clear (clear),
      .bus   (if4.slave)
   );

   bitmask_prev_constant_popcount_enumerator #(.WORD_WIDTH(8), .INDEX_WIDTH(16)) dut8 (
      .clock (clock),
      .clear (clear),
      .bus   (if8.slave)
   );

   // Free-running clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Largest smaller value with equal popcount, or -1 if none exists.
   function automatic int prev_model(input int x);
      for (int y = x - 1; y >= 0; y--) begin
         if ($countones(y) == $countones(x)) return y;
      end
      return -1;
   endfunction

   // Queue the full expected run for a start word.
   task automatic push_run(input int width, input int start);
      exp_t e;
      int   x;
      int   p;
      x = start;
      for (int idx = 0; idx < 300; idx++) begin
         p       = prev_model(x);
         e.word  = 8'(x);
         e.index = idx;
         e.last  = (p < 0);
         if (width == 4) q4.push_back(e);
         else            q8.push_back(e);
         if (p < 0) break;
         x = p;
      end
   endtask

   // Offer a start word to the 4-bit instance for one cycle (called at a negedge).
   task automatic start4(input logic [3:0] w);
      if4.start_valid = 1'b1;
      if4.start_word  = w;
      @(negedge clock);
      if4.start_valid = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      repeat (3) @(negedge clock);
      vectors++;
      if (if4.start_ready !== 1'b1 || if4.out_valid !== 1'b0 || if4.out_last !== 1'b0 ||
          if4.out_word !== 4'b0 || if4.out_index !== 16'd0 || if4.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_w4: got ready=%b valid=%b last=%b word=%b index=%0d busy=%b, expected 1 0 0 0000 0 0",
                  if4.start_ready, if4.out_valid, if4.out_last, if4.out_word, if4.out_index, if4.busy);
      end
      vectors++;
      if (if8.start_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.out_last !== 1'b0 ||
          if8.out_word !== 8'b0 || if8.out_index !== 16'd0 || if8.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_w8: got ready=%b valid=%b last=%b word=%b index=%0d busy=%b, expected 1 0 0 00000000 0 0",
                  if8.start_ready, if8.out_valid, if8.out_last, if8.out_word, if8.out_index, if8.busy);
      end
      clear = 1'b0;
      @(negedge clock);
   endtask

   // Full run of 1100 with out_ready held high; one beat per cycle.
   task automatic test_basic_sequence();
      exp_t e;
      int   cycles;
      push_run(4, 4'b1100);
      if4.out_ready = 1'b1;
      start4(4'b1100);
      cycles = 0;
      while (q4.size() > 0 && cycles < 40) begin
         e = q4[0];
         vectors++;
         if (if4.out_valid !== 1'b1 || if4.busy !== 1'b1 || if4.out_word !== e.word[3:0] ||
             if4.out_index !== 16'(e.index) || if4.out_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL basic_beat%0d: got valid=%b word=%b index=%0d last=%b, expected word=%b index=%0d last=%b",
                     e.index, if4.out_valid, if4.out_word, if4.out_index, if4.out_last, e.word[3:0], e.index, e.last);
         end
         void'(q4.pop_front());
         @(negedge clock);
         cycles++;
      end
      vectors++;
      if (q4.size() != 0 || if4.out_valid !== 1'b0 || if4.start_ready !== 1'b1 || if4.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_end: got pending=%0d valid=%b ready=%b busy=%b, expected 0 0 1 0",
                  q4.size(), if4.out_valid, if4.start_ready, if4.busy);
      end
      q4.delete();
   endtask

   // Degenerate starts 0000 and 1111 each produce a single final beat.
   task automatic test_single_beat();
      logic [3:0] starts [2];
      exp_t       e;
      starts[0] = 4'b0000;
      starts[1] = 4'b1111;
      if4.out_ready = 1'b1;
      for (int s = 0; s < 2; s++) begin
         push_run(4, int'(starts[s]));
         start4(starts[s]);
         e = q4[0];
         vectors++;
         if (q4.size() != 1 || if4.out_valid !== 1'b1 || if4.out_word !== e.word[3:0] ||
             if4.out_index !== 16'd0 || if4.out_last !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_%b: got valid=%b word=%b index=%0d last=%b queued=%0d, expected 1 %b 0 1 1",
                     starts[s], if4.out_valid, if4.out_word, if4.out_index, if4.out_last, q4.size(), e.word[3:0]);
         end
         q4.delete();
         @(negedge clock);
         vectors++;
         if (if4.out_valid !== 1'b0 || if4.start_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_%b_idle: got valid=%b ready=%b, expected 0 1",
                     starts[s], if4.out_valid, if4.start_ready);
         end
      end
   endtask

   // Stalls on out_ready must hold the current beat without skipping or repeating.
   task automatic test_backpressure();
      logic pattern [5];
      exp_t e;
      int   cycles;
      pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1; pattern[4] = 1'b1;
      push_run(4, 4'b0110);
      if4.out_ready = 1'b1;
      start4(4'b0110);
      cycles = 0;
      while (q4.size() > 0 && cycles < 40) begin
         if4.out_ready = (cycles < 5) ? pattern[cycles] : 1'b1;
         e = q4[0];
         vectors++;
         if (if4.out_valid !== 1'b1 || if4.out_word !== e.word[3:0] ||
             if4.out_index !== 16'(e.index) || if4.out_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL stall_cycle%0d: got valid=%b word=%b index=%0d last=%b, expected word=%b index=%0d last=%b",
                     cycles, if4.out_valid, if4.out_word, if4.out_index, if4.out_last, e.word[3:0], e.index, e.last);
         end
         if (if4.out_ready) void'(q4.pop_front());
         @(negedge clock);
         cycles++;
      end
      if4.out_ready = 1'b1;
      vectors++;
      if (q4.size() != 0 || cycles != 5 || if4.out_valid !== 1'b0 || if4.start_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stall_end: got pending=%0d cycles=%0d valid=%b ready=%b, expected 0 5 0 1",
                  q4.size(), cycles, if4.out_valid, if4.start_ready);
      end
      q4.delete();
   endtask

   // A start request held during a run is refused and does not disturb the sequence.
   task automatic test_start_during_run();
      exp_t e;
      int   cycles;
      push_run(4, 4'b1100);
      if4.out_ready = 1'b1;
      start4(4'b1100);
      if4.start_valid = 1'b1;
      if4.start_word  = 4'b1111;
      cycles = 0;
      while (q4.size() > 0 && cycles < 40) begin
         e = q4[0];
         vectors++;
         if (if4.start_ready !== 1'b0 || if4.out_valid !== 1'b1 || if4.out_word !== e.word[3:0] ||
             if4.out_index !== 16'(e.index) || if4.out_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL busy_start_beat%0d: got ready=%b valid=%b word=%b index=%0d last=%b, expected 0 1 %b %0d %b",
                     e.index, if4.start_ready, if4.out_valid, if4.out_word, if4.out_index, if4.out_last,
                     e.word[3:0], e.index, e.last);
         end
         void'(q4.pop_front());
         if (q4.size() == 0) if4.start_valid = 1'b0;
         @(negedge clock);
         cycles++;
      end
      if4.start_valid = 1'b0;
      vectors++;
      if (q4.size() != 0 || if4.out_valid !== 1'b0 || if4.start_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL busy_start_end: got pending=%0d valid=%b ready=%b, expected 0 0 1",
                  q4.size(), if4.out_valid, if4.start_ready);
      end
      q4.delete();
   endtask

   // Clear coinciding with an accepted beat abandons the run; a new start begins at index 0.
   task automatic test_clear_mid_run();
      exp_t e;
      int   cycles;
      push_run(4, 4'b1100);
      if4.out_ready = 1'b1;
      start4(4'b1100);
      cycles = 0;
      while (q4.size() > 0 && cycles < 40) begin
         e = q4[0];
         vectors++;
         if (if4.out_valid !== 1'b1 || if4.out_word !== e.word[3:0] || if4.out_index !== 16'(e.index)) begin
            miscompares++;
            $display("[TB] FAIL preclear_beat%0d: got valid=%b word=%b index=%0d, expected 1 %b %0d",
                     e.index, if4.out_valid, if4.out_word, if4.out_index, e.word[3:0], e.index);
         end
         if (e.index == 2) begin
            clear = 1'b1;
            break;
         end
         void'(q4.pop_front());
         @(negedge clock);
         cycles++;
      end
      q4.delete();
      @(negedge clock);
      clear = 1'b0;
      vectors++;
      if (if4.out_valid !== 1'b0 || if4.out_word !== 4'b0 || if4.out_index !== 16'd0 ||
          if4.start_ready !== 1'b1 || if4.out_last !== 1'b0 || if4.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL after_clear: got valid=%b word=%b index=%0d ready=%b last=%b busy=%b, expected 0 0000 0 1 0 0",
                  if4.out_valid, if4.out_word, if4.out_index, if4.start_ready, if4.out_last, if4.busy);
      end
      push_run(4, 4'b1010);
      start4(4'b1010);
      cycles = 0;
      while (q4.size() > 0 && cycles < 40) begin
         e = q4[0];
         vectors++;
         if (if4.out_valid !== 1'b1 || if4.out_word !== e.word[3:0] ||
             if4.out_index !== 16'(e.index) || if4.out_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL restart_beat%0d: got valid=%b word=%b index=%0d last=%b, expected word=%b index=%0d last=%b",
                     e.index, if4.out_valid, if4.out_word, if4.out_index, if4.out_last, e.word[3:0], e.index, e.last);
         end
         void'(q4.pop_front());
         @(negedge clock);
         cycles++;
      end
      vectors++;
      if (q4.size() != 0 || if4.out_valid !== 1'b0 || if4.start_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL restart_end: got pending=%0d valid=%b ready=%b, expected 0 0 1",
                  q4.size(), if4.out_valid, if4.start_ready);
      end
      q4.delete();
   endtask

   // 8-bit run from 11110000: 70 strictly decreasing beats, all of popcount 4.
   task automatic test_wide_word();
      exp_t       e;
      int         cycles;
      int         beats;
      logic [7:0] last_word;
      push_run(8, 8'b11110000);
      if8.out_ready   = 1'b1;
      if8.start_valid = 1'b1;
      if8.start_word  = 8'b11110000;
      @(negedge clock);
      if8.start_valid = 1'b0;
      cycles    = 0;
      beats     = 0;
      last_word = 8'hFF;
      while (q8.size() > 0 && cycles < 200) begin
         e = q8[0];
         vectors++;
         if (if8.out_valid !== 1'b1 || if8.out_word !== e.word || if8.out_index !== 16'(e.index) ||
             if8.out_last !== e.last || $countones(if8.out_word) != 4 ||
             (beats > 0 && !(if8.out_word < last_word))) begin
            miscompares++;
            $display("[TB] FAIL wide_beat%0d: got valid=%b word=%b index=%0d last=%b, expected word=%b index=%0d last=%b below %b",
                     e.index, if8.out_valid, if8.out_word, if8.out_index, if8.out_last,
                     e.word, e.index, e.last, last_word);
         end
         last_word = if8.out_word;
         void'(q8.pop_front());
         beats++;
         @(negedge clock);
         cycles++;
      end
      vectors++;
      if (q8.size() != 0 || beats != 70 || last_word !== 8'b00001111 || if8.out_valid !== 1'b0 ||
          if8.start_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wide_end: got pending=%0d beats=%0d final=%b valid=%b ready=%b, expected 0 70 00001111 0 1",
                  q8.size(), beats, last_word, if8.out_valid, if8.start_ready);
      end
      q8.delete();
   endtask

   // Test sequence.
   initial begin
      vectors         = 0;
      miscompares     = 0;
      clear           = 1'b1;
      if4.start_valid = 1'b0;
      if4.start_word  = '0;
      if4.out_ready   = 1'b0;
      if8.start_valid = 1'b0;
      if8.start_word  = '0;
      if8.out_ready   = 1'b0;
      @(negedge clock);
      test_reset();
      test_basic_sequence();
      test_single_beat();
      test_backpressure();
      test_start_during_run();
      test_clear_mid_run();
      test_wide_word();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bitmask_prev_constant_popcount_enumerator.md
Name: bitmask_prev_constant_popcount_enumerator

Overview:
Sequential enumerator that walks bitmasks downward in numeric order while keeping the popcount constant. It is the descending counterpart of the next-bitmask-with-constant-popcount element. It accepts a start word over a valid/ready handshake, then streams that word and every smaller word with the same popcount, one per accepted output beat. The final beat is the smallest such word (all ones packed at the LSB end), marked with out_last. It is used to drive combination searches and masks, from the top down, into downstream pipelines.

Parameters:
WORD_WIDTH, 8, bitmask width; legal values are ≥ 2.
INDEX_WIDTH, 16, width of the output beat index counter.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
clear  input  1  synchronous, active-high reset.
start_valid  input  1  a start word is offered.
start_ready  output  1  enumerator is idle and can accept a start word.
start_word  input  WORD_WIDTH  first (largest) mask of the sequence.
out_valid  output  1  out_word is valid.
out_ready  input  1  downstream accepts out_word.
out_word  output  WORD_WIDTH  current mask.
out_last  output  1  out_word is the final (smallest) mask for this popcount.
out_index  output  INDEX_WIDTH  0-based position of out_word within the current run.
busy  output  1  a run is in progress (state is RUN).

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous, active-high, named clear. clear has priority over every other input.
- State machine: two states, IDLE and RUN.
- Reset values: state=IDLE, start_ready=1, out_valid=0, out_last=0, out_word=0, out_index=0, busy=0.
- IDLE: start_ready=1 and out_valid=0. When start_valid=1 at an edge:
  - load out_word=start_word and out_index=0;
  - set out_valid=1 and enter RUN.
  - Latency is 1 cycle from start acceptance to the first out_valid.
- RUN: start_ready=0; start_valid is ignored.
  - out_word, out_last and out_index hold stable while out_valid=1 and out_ready=0.
- Beat handshake: a beat transfers on an edge with out_valid=1 and out_ready=1.
  - If out_last=0: out_word <= prev(out_word), out_index <= out_index+1, out_valid stays 1. Throughput is one beat per cycle.
  - If out_last=1: go to IDLE, out_valid <= 0, start_ready <= 1 on the next cycle. A new start therefore needs at least one idle cycle.
- prev(x): the largest word smaller than x with the same popcount. It is computed combinationally as prev(x) = ~next(~x), where next is the Gosper next-mask step (isolate rightmost 1, add, restore lost ones) on the complemented word.
  - Arithmetic is WORD_WIDTH bits; the carry out of the complement step is discarded.
- out_last is combinational from out_word: out_last = ((out_word & (out_word + 1)) == 0), i.e. all set bits are contiguous from bit 0.
  - Consequently start_word=0 yields a single beat with out_last=1.
  - All-ones yields a single beat with out_last=1.
  - A start word that is already minimal (e.g. 0011) yields a single beat.
- out_index wraps modulo 2^INDEX_WIDTH silently. The run is not terminated on wrap.
- Simultaneous events:
  - start_valid while in RUN is not accepted; start_ready=0.
  - clear asserted in the same cycle as a handshake: clear wins, and the state returns to IDLE with all outputs at their reset values.
- Reset mid-run: the in-flight sequence is abandoned and no further beats are produced. The first post-clear start begins a fresh run at index 0.
- Popcount is never altered: every out_word has the same popcount as start_word.

Test Plan:
1. WORD_WIDTH=4, start_word=1100, out_ready=1 held -> beats 1100,1010,1001,0110,0101,0011 on 6 consecutive cycles; out_index 0..5; out_last=1 only on 0011; start_ready=1 the cycle after.
2. start_word=0000, then separately 1111 -> each gives exactly one beat, out_last=1, out_index=0, then IDLE.
3. start_word=0110 with out_ready toggling 1,0,0,1,1 -> out_word holds 0101 through the stall cycles; sequence is 0110,0101,0011 with no duplicated or skipped beat.
4. Assert start_valid with start_word=1111 during run of 1100 -> start_ready=0, the request is ignored, and the original sequence completes unchanged.
5. clear asserted at the beat 1001 (index 2), simultaneous with out_ready=1 -> next cycle out_valid=0, out_word=0, out_index=0, start_ready=1; new start 1010 -> 1010,1001,0110,0101,0011.
6. WORD_WIDTH=8, start_word=11110000 -> 70 beats ending at 00001111; out_index ends at 69; every beat has popcount 4 and is strictly decreasing.
